// File: rtl/mem_wait_responder.sv
// Data-memory responder: services load/store requests from an internal word array after WAIT_CYCLES wait states.
// Define MEM_ACCESS_COUNT_EN to add saturating rd_count/wr_count outputs for successful accesses.
module mem_wait_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        busy,
    output logic        addr_error
`ifdef MEM_ACCESS_COUNT_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic                    err_q, err_d;
    logic [31:0]             read_data_q;

    logic [31:0]             mem_array [0:(2**ADDR_WIDTH)-1];

    logic                    req_err;
    logic                    enter_resp;
    logic                    in_idle;
    logic [ADDR_WIDTH-1:0]   acc_idx;
    logic [31:0]             acc_wdata;
    logic                    acc_rd, acc_wr, acc_err;
    logic                    mem_we, rd_en;

    assign req_err = (address[1:0] != 2'b00)
                   | ((address >> (ADDR_WIDTH + 2)) != 32'd0)
                   | (memread & memwrite);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (memread | memwrite) begin
                    idx_d   = address[ADDR_WIDTH+1:2];
                    wdata_d = write_data;
                    rd_d    = memread;
                    wr_d    = memwrite;
                    err_d   = req_err;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // With zero wait states RESP is entered on the acceptance edge, so the live request is used.
    assign in_idle   = (state_q == IDLE);
    assign acc_idx   = in_idle ? address[ADDR_WIDTH+1:2] : idx_q;
    assign acc_wdata = in_idle ? write_data : wdata_q;
    assign acc_rd    = in_idle ? memread : rd_q;
    assign acc_wr    = in_idle ? memwrite : wr_q;
    assign acc_err   = in_idle ? req_err : err_q;

    // The array has no reset, so writes are explicitly blocked while reset is held.
    assign mem_we = enter_resp & acc_wr & ~acc_err & ~reset;
    assign rd_en  = enter_resp & acc_rd & ~acc_err;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_array[acc_idx] <= acc_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            wdata_q     <= 32'd0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            read_data_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            if (rd_en) begin
                read_data_q <= mem_array[acc_idx];
            end
        end
    end

    assign read_data  = read_data_q;
    assign ready      = (state_q == RESP);
    assign busy       = (state_q != IDLE);
    assign addr_error = (state_q == RESP) & err_q;

`ifdef MEM_ACCESS_COUNT_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (rd_en && rd_count_q != 16'hFFFF) begin
            rd_count_d = rd_count_q + 16'd1;
        end
        if (enter_resp && acc_wr && !acc_err && wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

// File: doc/mem_wait_responder.md
Name: mem_wait_responder

Overview:
- Responder end of the processor's data-memory interface: accepts load/store requests (memread/memwrite, byte address, write data) and services them from an internal word array after a fixed number of wait states.
- Signals completion with a one-cycle ready pulse.
- Sits between the multicycle/pipelined core variants and the data storage, replacing the zero-latency Datamemory when realistic memory timing is needed.
- Flags misaligned, out-of-range and conflicting requests instead of accessing memory.

Parameters:
- ADDR_WIDTH, 10, word-address bits; array holds 2**ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, wait states between acceptance and completion (legal range 0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- memread  input  1  load request, level; held by initiator until ready.
- memwrite  input  1  store request, level; held by initiator until ready.
- address  input  32  byte address.
- write_data  input  32  store data.
- read_data  output  32  load result; valid in the ready cycle and held until the next successful load completes.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high from acceptance until the ready cycle, inclusive.
- addr_error  output  1  qualifies ready; high only in the ready cycle of a rejected request.

Behaviour:
- FSM states: IDLE, WAIT, RESP. Reset forces IDLE.
- Reset values: read_data=0, ready=0, busy=0, addr_error=0, wait counter=0. The array is not cleared by reset.
- Acceptance:
  - A request is accepted at the rising edge E0 where the state is IDLE and (memread | memwrite)=1.
  - At E0, capture address, write_data, op and the error condition.
- Error condition (evaluated at E0):
  - address[1:0]!=0, or
  - address[31:ADDR_WIDTH+2]!=0, or
  - memread & memwrite both 1.
- State flow:
  - WAIT_CYCLES=0: IDLE→RESP at E0.
  - WAIT_CYCLES>0: IDLE→WAIT at E0 with counter=WAIT_CYCLES-1. WAIT decrements each edge; counter==0 gives WAIT→RESP.
  - RESP→IDLE unconditionally at the next edge.
- Completion timing:
  - ready=1 during the single cycle following edge E0+WAIT_CYCLES.
  - busy=1 from after E0 through that cycle.
- Store: the array word at address[ADDR_WIDTH+1:2] is written on the edge entering RESP. Never written on an error.
- Load: read_data is registered on the edge entering RESP. On an error, read_data keeps its previous value.
- Error completion: identical latency, ready=1 and addr_error=1, no array access.
- Requests during WAIT/RESP are ignored. Request levels are sampled only in IDLE, so back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
- If the initiator still holds a request after ready, it is accepted again at the first IDLE edge. The initiator must drop the request during the ready cycle.
- Address and write_data changes after E0 have no effect (captured copy used).
- Reset asserted mid-operation: immediate return to IDLE, outputs to reset values, pending store abandoned (array unmodified), pending load discarded.

Optional Feature:
- Macro MEM_ACCESS_COUNT_EN.
- When defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - Each counter increments on the edge entering RESP for a successful load or store respectively.
  - Both saturate at 16'hFFFF, are unaffected by error completions, and reset to 0.
- When undefined: ports and logic are absent, and behaviour is otherwise identical.

Test Plan:
- WAIT_CYCLES=2: store 32'hDEADBEEF to address 32'h0000_0010, then load from 32'h10 → each ready pulse comes 3 cycles after acceptance, read_data=32'hDEADBEEF, addr_error=0.
- Load from address 32'h0000_0012 (misaligned) after the prior test → ready+addr_error at the same latency, read_data stays 32'hDEADBEEF, word 4 unchanged.
- ADDR_WIDTH=10: store to 32'h0000_1000 → addr_error=1, a subsequent load of 32'h0 returns its prior contents unchanged.
- memread=memwrite=1 at 32'h8 → addr_error=1, no write; address changed during WAIT → ignored, captured address used.
- Assert reset during WAIT of a store of 32'h12345678 to 32'h20 → outputs zero immediately; a later load of 32'h20 returns the old value.
- WAIT_CYCLES=0 with request held continuously → ready every 2nd cycle. With MEM_ACCESS_COUNT_EN, after 3 loads and 2 stores: rd_count=3, wr_count=2.
